aesl_deadlock_timeout_detector: RTL and testbench
=================================================

AESL_DEADLOCK_TIMEOUT_DETECTOR -- requirements
Module: aesl_deadlock_timeout_detector

Interface
REQ-001 Parameter TIMEOUT, default 1000: consecutive blocked cycles before a deadlock is declared; legal range 2..2^20.
REQ-002 Parameter NUM_AXIS, default 4: number of 4-bit axis fields in the block-info word.
REQ-003 Port: clock, in, 1, the only clock; every flop samples on the rising edge.
REQ-004 Port: reset, in, 1, synchronous, active-high.
REQ-005 Port: block, in, 1, aggregated block flag from the per-instance deadlock monitor.
REQ-006 Port: axis_block_info, in, 4*NUM_AXIS, per-axis block fields; nibble k nonzero means axis k is blocked.
REQ-007 Port: kernel_done, in, 1, DUT completion pulse.
REQ-008 Port: report_ready, in, 1, testbench ready to accept the report.
REQ-009 Port: report_valid, out, 1, report pending.
REQ-010 Port: deadlock_detected, out, 1, sticky deadlock flag.
REQ-011 Port: deadlock_info, out, 4*NUM_AXIS, axis_block_info captured at detection.
REQ-012 Port: first_axis, out, clog2(NUM_AXIS) (min 1), lowest-index axis with a nonzero nibble in deadlock_info.
REQ-013 Port: axis_found, out, 1, high when deadlock_info has any nonzero nibble.
REQ-014 Port: detect_cycle, out, 32, value of the free-running cycle counter at detection.

Function
REQ-015 The FSM has exactly four states: IDLE, WATCH, DEADLOCK, REPORTED.
REQ-016 IDLE: block=1 -> WATCH, with run counter loaded to 1; otherwise stay.
REQ-017 WATCH: block=0 or kernel_done=1 -> IDLE, with run counter cleared; kernel_done has priority over block.
REQ-018 WATCH: block=1 with run counter = TIMEOUT-1 -> DEADLOCK; otherwise the run counter increments by 1.
REQ-019 A change in axis_block_info while block stays 1 neither restarts nor pauses the run counter.
REQ-020 On the WATCH->DEADLOCK edge, the block captures axis_block_info into deadlock_info and the cycle counter into detect_cycle; deadlock_detected and report_valid assert in the next cycle.
REQ-021 Net latency: block first sampled high at cycle N -> deadlock_detected high at cycle N+TIMEOUT, provided block stays high through cycle N+TIMEOUT-1.
REQ-022 DEADLOCK: report_valid=1; report_ready=1 -> REPORTED and report_valid deasserts next cycle; report_valid never drops without report_ready.
REQ-023 REPORTED: terminal until reset; block and kernel_done are ignored; report_valid=0 and deadlock_detected=1.
REQ-024 In DEADLOCK and REPORTED, deadlock_info, detect_cycle, first_axis and axis_found stay frozen.
REQ-025 first_axis and axis_found are decoded combinationally from the registered deadlock_info; if no nibble is set, first_axis=0 and axis_found=0.
REQ-026 The run counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps.
REQ-027 The 32-bit cycle counter increments every cycle after reset and wraps modulo 2^32.

Reset
REQ-028 reset=1 -> state IDLE, run counter 0, cycle counter 0, report_valid 0, deadlock_detected 0, deadlock_info 0, detect_cycle 0 (hence first_axis 0, axis_found 0).
REQ-029 Reset in any state, including mid-WATCH or with a report pending, fully returns the block to the REQ-028 state in the next cycle; any pending report is dropped.

Structure
REQ-030 Shared package aesl_deadlock_pkg holds: the state enum (IDLE/WATCH/DEADLOCK/REPORTED), AXIS_FIELD_W=4, CYCLE_W=32.
REQ-031 One sub-module, aesl_deadlock_axis_decode: a parameterized lowest-index nonzero-nibble priority encoder producing first_axis/axis_found.

Verification (TIMEOUT=8, NUM_AXIS=4)
REQ-032 Test 1: block high for 7 cycles then low -> no deadlock_detected; state returns to IDLE; then block high for 8 cycles -> deadlock_detected at cycle start+8.
REQ-033 Test 2: block high continuously, axis_block_info=16'h00D0 at the capture edge -> deadlock_info=16'h00D0, first_axis=1, axis_found=1.
REQ-034 Test 3: report_ready held 0 for 5 cycles after report_valid rises, then pulsed 1 -> report_valid stable for those 5 cycles, 0 after the accept; deadlock_detected stays 1.
REQ-035 Test 4: kernel_done and block both 1 in WATCH at count 5 -> IDLE, no detection; block held high afterwards -> detection 8 cycles after re-entry.
REQ-036 Test 5: reset asserted while report_valid=1 -> all outputs 0 the next cycle; a new 8-cycle block re-detects, with detect_cycle measured from reset release.
REQ-037 Test 6: block high with axis_block_info=0 -> deadlock_detected=1, axis_found=0, first_axis=0.

Source files
------------

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and widths for the deadlock timeout detector.
package aesl_deadlock_pkg;

    localparam int AXIS_FIELD_W = 4;
    localparam int CYCLE_W      = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2,
        REPORTED = 2'd3
    } state_t;

endpackage

// File: rtl/aesl_deadlock_axis_decode.sv
// Lowest-index nonzero-nibble priority encoder over the captured block-info word.
module aesl_deadlock_axis_decode
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 4,
    parameter int FA_W     = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic [AXIS_FIELD_W*NUM_AXIS-1:0] info,
    output logic [FA_W-1:0]                  first_axis,
    output logic                             axis_found
);

    // Scan high to low so the last hit (lowest index) wins.
    always_comb begin
        first_axis = '0;
        axis_found = 1'b0;
        for (int k = NUM_AXIS - 1; k >= 0; k--) begin
            if (|info[k*AXIS_FIELD_W +: AXIS_FIELD_W]) begin
                first_axis = FA_W'(k);
                axis_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aesl_deadlock_timeout_detector.sv
// Declares a deadlock after TIMEOUT consecutive blocked cycles and holds a report until accepted.
module aesl_deadlock_timeout_detector
    import aesl_deadlock_pkg::*;
#(
    parameter int TIMEOUT  = 1000,
    parameter int NUM_AXIS = 4,
    parameter int FA_W     = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             block,
    input  logic [AXIS_FIELD_W*NUM_AXIS-1:0] axis_block_info,
    input  logic                             kernel_done,
    input  logic                             report_ready,
    output logic                             report_valid,
    output logic                             deadlock_detected,
    output logic [AXIS_FIELD_W*NUM_AXIS-1:0] deadlock_info,
    output logic [FA_W-1:0]                  first_axis,
    output logic                             axis_found,
    output logic [CYCLE_W-1:0]               detect_cycle
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    state_t             state, next_state;
    logic [RUN_W-1:0]   run_cnt, run_next;
    logic [CYCLE_W-1:0] cycle_cnt;
    logic               capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            run_cnt       <= '0;
            cycle_cnt     <= '0;
            deadlock_info <= '0;
            detect_cycle  <= '0;
        end else begin
            state     <= next_state;
            run_cnt   <= run_next;
            cycle_cnt <= cycle_cnt + 1'b1;
            if (capture) begin
                deadlock_info <= axis_block_info;
                detect_cycle  <= cycle_cnt;
            end
        end
    end

    // Run counter holds at TIMEOUT-1 once the deadlock is declared, so it never wraps.
    always_comb begin
        next_state = state;
        run_next   = run_cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (block) begin
                    next_state = WATCH;
                    run_next   = RUN_W'(1);
                end
            end
            WATCH: begin
                if (kernel_done || !block) begin
                    next_state = IDLE;
                    run_next   = '0;
                end else if (run_cnt == RUN_W'(TIMEOUT - 1)) begin
                    next_state = DEADLOCK;
                    capture    = 1'b1;
                end else begin
                    run_next = run_cnt + 1'b1;
                end
            end
            DEADLOCK: begin
                if (report_ready) next_state = REPORTED;
            end
            REPORTED: ;
            default: next_state = IDLE;
        endcase
    end

    assign report_valid      = (state == DEADLOCK);
    assign deadlock_detected = (state == DEADLOCK) || (state == REPORTED);

    aesl_deadlock_axis_decode #(
        .NUM_AXIS (NUM_AXIS),
        .FA_W     (FA_W)
    ) u_decode (
        .info       (deadlock_info),
        .first_axis (first_axis),
        .axis_found (axis_found)
    );

endmodule

// File: tb/tb_aesl_deadlock_timeout_detector.sv
// Directed scoreboard bench for the deadlock timeout detector (TIMEOUT=8, NUM_AXIS=4).
module tb_aesl_deadlock_timeout_detector;

    localparam int TIMEOUT  = 8;
    localparam int NUM_AXIS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        block;
    logic [15:0] axis_block_info;
    logic        kernel_done;
    logic        report_ready;
    logic        report_valid;
    logic        deadlock_detected;
    logic [15:0] deadlock_info;
    logic [1:0]  first_axis;
    logic        axis_found;
    logic [31:0] detect_cycle;

    typedef struct {
        logic [15:0] info;
        logic [1:0]  fa;
        logic        found;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    aesl_deadlock_timeout_detector #(
        .TIMEOUT  (TIMEOUT),
        .NUM_AXIS (NUM_AXIS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .block             (block),
        .axis_block_info   (axis_block_info),
        .kernel_done       (kernel_done),
        .report_ready      (report_ready),
        .report_valid      (report_valid),
        .deadlock_detected (deadlock_detected),
        .deadlock_info     (deadlock_info),
        .first_axis        (first_axis),
        .axis_found        (axis_found),
        .detect_cycle      (detect_cycle)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cyc tracks the DUT cycle-counter value that the next edge will see.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic expect_report(input logic [15:0] info, input logic [1:0] fa,
                                 input logic found, input logic [31:0] c);
        exp_t e;
        e.info = info; e.fa = fa; e.found = found; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: each rising edge of deadlock_detected must match the next queued report.
    initial begin
        logic prev_det;
        exp_t e;
        prev_det = 1'b0;
        forever begin
            @(negedge clock);
            if (deadlock_detected === 1'b1 && prev_det !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_detect: got detection with info %0h expected none", deadlock_info);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_info", 32'(deadlock_info), 32'(e.info));
                    check("mon_first_axis", 32'(first_axis), 32'(e.fa));
                    check("mon_axis_found", 32'(axis_found), 32'(e.found));
                    check("mon_detect_cycle", detect_cycle, e.cyc);
                    check("mon_report_valid", 32'(report_valid), 32'd1);
                end
            end
            prev_det = deadlock_detected;
        end
    end

    initial begin
        block = 1'b0; axis_block_info = '0; kernel_done = 1'b0; report_ready = 1'b0;
        reset = 1'b1;
        tick();
        do_reset();
        check("rst_report_valid", 32'(report_valid), 0);
        check("rst_detected", 32'(deadlock_detected), 0);
        check("rst_info", 32'(deadlock_info), 0);
        check("rst_detect_cycle", detect_cycle, 0);
        check("rst_first_axis", 32'(first_axis), 0);
        check("rst_axis_found", 32'(axis_found), 0);

        // Test 1: 7 blocked cycles is one short; 8 detects.
        axis_block_info = 16'h0300;
        block = 1'b1;
        repeat (7) tick();
        block = 1'b0;
        repeat (2) tick();
        check("t1_short_no_detect", 32'(deadlock_detected), 0);
        expect_report(16'h0300, 2'd2, 1'b1, 32'(cyc + TIMEOUT - 1));
        block = 1'b1;
        repeat (7) tick();
        check("t1_not_yet", 32'(deadlock_detected), 0);
        tick();
        check("t1_detect_at_8", 32'(deadlock_detected), 1);

        // Test 2: info changes mid-run without restarting; 00D0 present at capture.
        do_reset();
        block = 1'b0;
        axis_block_info = 16'h1000;
        expect_report(16'h00D0, 2'd1, 1'b1, 32'(cyc + TIMEOUT - 1));
        block = 1'b1;
        repeat (4) tick();
        axis_block_info = 16'h00D0;
        repeat (3) tick();
        check("t2_not_yet", 32'(deadlock_detected), 0);
        tick();
        check("t2_detect", 32'(deadlock_detected), 1);

        // Test 3: report held until accepted, then REPORTED ignores inputs.
        report_ready = 1'b0;
        repeat (5) begin
            check("t3_valid_held", 32'(report_valid), 1);
            tick();
        end
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        check("t3_valid_drop", 32'(report_valid), 0);
        check("t3_detect_sticky", 32'(deadlock_detected), 1);
        block = 1'b0; kernel_done = 1'b1; axis_block_info = 16'hFFFF;
        repeat (3) tick();
        kernel_done = 1'b0;
        check("t3_reported_detect", 32'(deadlock_detected), 1);
        check("t3_reported_valid", 32'(report_valid), 0);
        check("t3_info_frozen", 32'(deadlock_info), 32'h00D0);

        // Test 4: kernel_done wins at count 5; detection 8 cycles after re-entry.
        block = 1'b0;
        do_reset();
        axis_block_info = 16'h0050;
        block = 1'b1;
        tick();
        repeat (4) tick();
        kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;
        check("t4_abort_no_detect", 32'(deadlock_detected), 0);
        expect_report(16'h0050, 2'd1, 1'b1, 32'(cyc + TIMEOUT - 1));
        repeat (7) tick();
        check("t4_not_yet", 32'(deadlock_detected), 0);
        tick();
        check("t4_detect", 32'(deadlock_detected), 1);

        // Test 5: reset with report pending clears everything; re-detect from release.
        check("t5_pending", 32'(report_valid), 1);
        block = 1'b0;
        reset = 1'b1;
        tick();
        check("t5_rst_valid", 32'(report_valid), 0);
        check("t5_rst_detected", 32'(deadlock_detected), 0);
        check("t5_rst_info", 32'(deadlock_info), 0);
        check("t5_rst_cycle", detect_cycle, 0);
        check("t5_rst_first_axis", 32'(first_axis), 0);
        check("t5_rst_found", 32'(axis_found), 0);
        reset = 1'b0;
        cyc = 0;
        axis_block_info = 16'hA000;
        expect_report(16'hA000, 2'd3, 1'b1, 32'd7);
        block = 1'b1;
        repeat (8) tick();
        check("t5_redetect", 32'(deadlock_detected), 1);

        // Test 6: detection with no axis flagged.
        block = 1'b0;
        do_reset();
        axis_block_info = 16'h0000;
        expect_report(16'h0000, 2'd0, 1'b0, 32'(cyc + TIMEOUT - 1));
        block = 1'b1;
        repeat (8) tick();
        check("t6_detect", 32'(deadlock_detected), 1);
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
